turkey_gun_ctrl: RTL and testbench
==================================

# turkey_gun_ctrl

Joystick-to-lightgun position generator for the Turkey Shoot core. It turns digital direction inputs into the 6-bit absolute gun coordinates that the `williams2` core reads on its `gun_h`/`gun_v` inputs. Position moves in steps paced by the core's 4 ms tick, with hold-time acceleration and saturation at the screen edges. It sits in the top level between joystick decoding and `williams2`, in the `clock_12` domain.

## Interface

Parameters:
- `POS_W`, 6: integer width of each coordinate.
- `FRAC_W`, 4: fractional bits of the internal position accumulator.
- `H_MIN` / `H_MAX`, 0 / 63: horizontal clamp bounds.
- `V_MIN` / `V_MAX`, 0 / 63: vertical clamp bounds.
- `CENTER_H` / `CENTER_V`, 32 / 32: position after reset or recenter.
- `ACC1_TICKS`, 8: hold ticks before the medium speed applies.
- `ACC2_TICKS`, 24: hold ticks before the fast speed applies.

Ports:
- `clock_12`  in  1: core clock.
- `reset`  in  1: asynchronous, active-high reset.
- `tick_4ms`  in  1: level from `williams2` `cnt_4ms_o`; each rising edge is one motion tick.
- `recenter`  in  1: one-cycle synchronous pulse; returns both axes to center.
- `m_left`, `m_right`, `m_up`, `m_down`  in  1 each: active-high directions.
- `gun_h`  out  `POS_W`: horizontal position, integer part.
- `gun_v`  out  `POS_W`: vertical position, integer part.

## Operation

- **Tick edge.** `tick_prev` resets to 1. A tick is the condition `tick_4ms & ~tick_prev`. A high `tick_4ms` at reset release does not count.
- **Per-axis state.**
  - `pos`: `POS_W+FRAC_W` bits, unsigned fixed point.
  - `hold`: 8-bit tick counter, saturates at 255.
  - `dir_prev`: 2 bits, one of {none, neg, pos}.
- **Axis direction.**
  - h: `m_right` = pos, `m_left` = neg.
  - v: `m_down` = pos, `m_up` = neg.
  - Both or neither pressed = none.
- **On a tick, per axis:**
  - dir = none: `hold` goes to 0 and `pos` is unchanged.
  - dir ≠ `dir_prev` (reversal or fresh press): `hold` is treated as 0 for this tick's step.
  - Step size in fractional units is chosen from `hold` before the increment:
    - `hold` < `ACC1_TICKS`: 4 (0.25 px).
    - `hold` < `ACC2_TICKS`: 8 (0.5 px).
    - otherwise: 16 (1 px).
  - `pos` ± step is clamped to [`MIN`<<`FRAC_W`, `MAX`<<`FRAC_W`]. Arithmetic is one bit wider than `pos`, so it neither underflows below 0 nor overflows.
  - After stepping, `hold` becomes min(`hold`+1, 255). On a fresh press or reversal this means `hold` = 1.
  - `dir_prev` takes the current dir.
- **No tick:** all state holds. Direction changes between ticks only take effect at the next tick.
- **Recenter:** `recenter`=1 sets `pos` to `CENTER`<<`FRAC_W` and `hold` to 0 on both axes. It has priority over a tick in the same cycle.
- **Outputs:** `gun_h`/`gun_v` = `pos[POS_W+FRAC_W-1:FRAC_W]` (floor of the position), taken directly from registers.

## Timing

- **Reset values:**
  - `gun_h` = `CENTER_H`, `gun_v` = `CENTER_V`.
  - Fractional bits = 0, `hold` = 0, `dir_prev` = none, `tick_prev` = 1.
- **Latency:** `tick_4ms` rises in cycle N and is sampled at edge N. The updated `gun_h`/`gun_v` are visible after clock edge N+1. Total: one-cycle edge detect plus registered update.
- **Recenter:** outputs show the center value one cycle after the pulse.
- **Reset mid-hold:** the state returns asynchronously to reset values. The first tick after release uses step 4.
- **Tick held high for many cycles:** produces exactly one step.
- **Axes:** the two axes are fully independent; diagonal motion updates both on the same tick.

## Structure

- **Shared package `turkey_gun_pkg`:**
  - Direction enum {`DIR_NONE`, `DIR_NEG`, `DIR_POS`}.
  - Step constants `STEP_SLOW`=4, `STEP_MED`=8, `STEP_FAST`=16.
  - Hold width 8.
- **Sub-module `turkey_gun_axis`:** one per axis.
  - Inputs: tick, recenter, neg, pos.
  - Parameters: MIN, MAX, CENTER.
  - Owns `pos`, `hold`, `dir_prev` and the clamp.
- **Top level:** owns only the tick edge detect and two axis instances.

## Test plan

1. **Reset:** release reset with `tick_4ms`=1 held, no input, 3 ticks → `gun_h`=32, `gun_v`=32 throughout; no step on release.
2. **Acceleration:**
   - Hold `m_right` for 24 ticks → `gun_h`=42 (8 ticks add 2 px, 16 ticks add 8 px).
   - 21 more ticks → 63.
   - Further ticks → stays 63.
   - `gun_v` stays 32 throughout.
3. **Fractional floor:** from reset, `m_left` for 1 tick → `gun_h`=31 (position 31.75); after 4 ticks total → 31; after 5 → 30.
4. **Reversal and conflicts:**
   - Hold `m_right` for 30 ticks, then switch to `m_left` → the next tick moves −0.25 px.
   - `m_left`+`m_right` together → no motion and `hold` = 0.
5. **Saturation and recenter:**
   - Hold `m_up` until `gun_v`=0, then 10 more ticks → stays 0, no wrap to 63.
   - `recenter` pulsed in the same cycle as a tick edge → `gun_v`=32 next cycle, no step applied.
6. **Asynchronous reset mid-motion:** assert `reset` mid-cycle during a fast right hold → outputs go to 32/32 immediately; after release, the first tick moves +0.25 px.

Source files
------------

// File: rtl/turkey_gun_pkg.sv
// Shared types and constants for the Turkey Shoot lightgun position generator.
package turkey_gun_pkg;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_NEG  = 2'd1,
      DIR_POS  = 2'd2
   } dir_e;

   localparam int HOLD_W    = 8;
   localparam int STEP_SLOW = 4;
   localparam int STEP_MED  = 8;
   localparam int STEP_FAST = 16;

endpackage

// File: rtl/turkey_gun_axis.sv
// One gun axis: fixed-point position with hold-time acceleration and edge clamp.
module turkey_gun_axis
   import turkey_gun_pkg::*;
#(
   parameter int POS_W      = 6,
   parameter int FRAC_W     = 4,
   parameter int MIN        = 0,
   parameter int MAX        = 63,
   parameter int CENTER     = 32,
   parameter int ACC1_TICKS = 8,
   parameter int ACC2_TICKS = 24
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tick_i,
   input  logic             recenter_i,
   input  logic             neg_i,
   input  logic             pos_i,
   output logic [POS_W-1:0] pos_o
);

   localparam int W = POS_W + FRAC_W;
   localparam logic [W:0]   LO    = (W+1)'(MIN << FRAC_W);
   localparam logic [W:0]   HI    = (W+1)'(MAX << FRAC_W);
   localparam logic [W-1:0] LO_N  = W'(MIN << FRAC_W);
   localparam logic [W-1:0] HI_N  = W'(MAX << FRAC_W);
   localparam logic [W-1:0] CTR_N = W'(CENTER << FRAC_W);

   logic [W-1:0]      pos_q, pos_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   dir_e              dir_q, dir_d;

   dir_e              dir;
   logic [HOLD_W-1:0] hold_eff;
   logic [W:0]        step;
   logic [W:0]        pos_ext;
   logic [W:0]        up_sum;
   logic [W:0]        dn_lim;
   logic [W-1:0]      stepped;

   always_comb begin
      dir = DIR_NONE;
      if (pos_i && !neg_i)
         dir = DIR_POS;
      else if (neg_i && !pos_i)
         dir = DIR_NEG;

      // a fresh press or reversal restarts acceleration from the slow step
      hold_eff = (dir != dir_q) ? '0 : hold_q;

      if (hold_eff < HOLD_W'(ACC1_TICKS))
         step = (W+1)'(STEP_SLOW);
      else if (hold_eff < HOLD_W'(ACC2_TICKS))
         step = (W+1)'(STEP_MED);
      else
         step = (W+1)'(STEP_FAST);

      pos_ext = {1'b0, pos_q};
      up_sum  = pos_ext + step;
      dn_lim  = LO + step;

      stepped = pos_q;
      if (dir == DIR_POS)
         stepped = (up_sum > HI) ? HI_N : up_sum[W-1:0];
      else if (dir == DIR_NEG)
         stepped = (pos_ext < dn_lim) ? LO_N : (pos_q - W'(step));

      pos_d  = pos_q;
      hold_d = hold_q;
      dir_d  = dir_q;
      if (recenter_i) begin
         pos_d  = CTR_N;
         hold_d = '0;
      end else if (tick_i) begin
         if (dir == DIR_NONE) begin
            hold_d = '0;
         end else begin
            pos_d  = stepped;
            hold_d = (hold_eff == '1) ? hold_eff : hold_eff + HOLD_W'(1);
         end
         dir_d = dir;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pos_q  <= CTR_N;
         hold_q <= '0;
         dir_q  <= DIR_NONE;
      end else begin
         pos_q  <= pos_d;
         hold_q <= hold_d;
         dir_q  <= dir_d;
      end
   end

   assign pos_o = pos_q[W-1:FRAC_W];

endmodule

// File: rtl/turkey_gun_ctrl.sv
// Joystick-to-lightgun coordinate generator: 4 ms tick edge detect plus two axes.
module turkey_gun_ctrl
   import turkey_gun_pkg::*;
#(
   parameter int POS_W      = 6,
   parameter int FRAC_W     = 4,
   parameter int H_MIN      = 0,
   parameter int H_MAX      = 63,
   parameter int V_MIN      = 0,
   parameter int V_MAX      = 63,
   parameter int CENTER_H   = 32,
   parameter int CENTER_V   = 32,
   parameter int ACC1_TICKS = 8,
   parameter int ACC2_TICKS = 24
) (
   input  logic             clock_12,
   input  logic             reset,
   input  logic             tick_4ms,
   input  logic             recenter,
   input  logic             m_left,
   input  logic             m_right,
   input  logic             m_up,
   input  logic             m_down,
   output logic [POS_W-1:0] gun_h,
   output logic [POS_W-1:0] gun_v
);

   logic tick_prev_q;
   logic tick_q;

   // tick_prev resets high so a tick level already present at release is ignored
   always_ff @(posedge clock_12 or posedge reset) begin
      if (reset) begin
         tick_prev_q <= 1'b1;
         tick_q      <= 1'b0;
      end else begin
         tick_prev_q <= tick_4ms;
         tick_q      <= tick_4ms & ~tick_prev_q;
      end
   end

   turkey_gun_axis #(
      .POS_W      (POS_W),
      .FRAC_W     (FRAC_W),
      .MIN        (H_MIN),
      .MAX        (H_MAX),
      .CENTER     (CENTER_H),
      .ACC1_TICKS (ACC1_TICKS),
      .ACC2_TICKS (ACC2_TICKS)
   ) u_axis_h (
      .clk_i      (clock_12),
      .rst_i      (reset),
      .tick_i     (tick_q),
      .recenter_i (recenter),
      .neg_i      (m_left),
      .pos_i      (m_right),
      .pos_o      (gun_h)
   );

   turkey_gun_axis #(
      .POS_W      (POS_W),
      .FRAC_W     (FRAC_W),
      .MIN        (V_MIN),
      .MAX        (V_MAX),
      .CENTER     (CENTER_V),
      .ACC1_TICKS (ACC1_TICKS),
      .ACC2_TICKS (ACC2_TICKS)
   ) u_axis_v (
      .clk_i      (clock_12),
      .rst_i      (reset),
      .tick_i     (tick_q),
      .recenter_i (recenter),
      .neg_i      (m_up),
      .pos_i      (m_down),
      .pos_o      (gun_v)
   );

endmodule

// File: tb/tb_turkey_gun_ctrl.sv
// Directed bench for turkey_gun_ctrl: behavioural position model feeding a scoreboard queue.
`timescale 1ns/1ps
module tb_turkey_gun_ctrl;

   logic       clock_12 = 1'b0;
   logic       reset    = 1'b1;
   logic       tick_4ms = 1'b1;
   logic       recenter = 1'b0;
   logic       m_left   = 1'b0;
   logic       m_right  = 1'b0;
   logic       m_up     = 1'b0;
   logic       m_down   = 1'b0;
   logic [5:0] gun_h;
   logic [5:0] gun_v;

   int tests = 0;
   int fails = 0;

   turkey_gun_ctrl dut (
      .clock_12 (clock_12),
      .reset    (reset),
      .tick_4ms (tick_4ms),
      .recenter (recenter),
      .m_left   (m_left),
      .m_right  (m_right),
      .m_up     (m_up),
      .m_down   (m_down),
      .gun_h    (gun_h),
      .gun_v    (gun_v)
   );

   always #5 clock_12 = ~clock_12;

   // model state, index 0 = horizontal, 1 = vertical; dir 0 none, 1 neg, 2 pos
   int m_pos  [2];
   int m_hold [2];
   int m_dir  [2];

   typedef struct {
      string tag;
      int    h;
      int    v;
   } exp_t;
   exp_t sbq[$];

   function automatic void model_reset();
      for (int a = 0; a < 2; a++) begin
         m_pos[a]  = 32 * 16;
         m_hold[a] = 0;
         m_dir[a]  = 0;
      end
   endfunction

   function automatic void model_recenter();
      for (int a = 0; a < 2; a++) begin
         m_pos[a]  = 32 * 16;
         m_hold[a] = 0;
      end
   endfunction

   function automatic void model_axis(int a, bit n, bit p);
      int d, he, st, np;
      d = (n && !p) ? 1 : ((p && !n) ? 2 : 0);
      if (d == 0) begin
         m_hold[a] = 0;
      end else begin
         he = (d != m_dir[a]) ? 0 : m_hold[a];
         st = (he < 8) ? 4 : ((he < 24) ? 8 : 16);
         np = (d == 2) ? m_pos[a] + st : m_pos[a] - st;
         if (np < 0)       np = 0;
         if (np > 63 * 16) np = 63 * 16;
         m_pos[a]  = np;
         m_hold[a] = (he >= 255) ? 255 : he + 1;
      end
      m_dir[a] = d;
   endfunction

   task automatic push_model(input string tag);
      sbq.push_back('{tag, m_pos[0] / 16, m_pos[1] / 16});
   endtask

   task automatic push_const(input string tag, input int h, input int v);
      sbq.push_back('{tag, h, v});
   endtask

   task automatic check_out();
      exp_t e;
      logic [5:0] eh, ev;
      if (sbq.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL sb_empty: observed 0 entries, required 1");
         return;
      end
      e  = sbq.pop_front();
      eh = 6'(e.h);
      ev = 6'(e.v);
      tests++;
      assert (gun_h === eh) else begin
         fails++;
         $error("FAIL %s gun_h: observed %0d required %0d", e.tag, gun_h, eh);
      end
      tests++;
      assert (gun_v === ev) else begin
         fails++;
         $error("FAIL %s gun_v: observed %0d required %0d", e.tag, gun_v, ev);
      end
   endtask

   task automatic check_all();
      while (sbq.size() > 0) check_out();
   endtask

   // one tick: rising tick_4ms sampled at edge N, result checked after edge N+1
   task automatic tick_step(input string tag, input int hold_cycles, input bit with_rc);
      @(posedge clock_12);
      #1 tick_4ms = 1'b1;
      @(posedge clock_12);
      #1;
      if (with_rc) begin
         recenter = 1'b1;
         model_recenter();
      end else begin
         model_axis(0, m_left, m_right);
         model_axis(1, m_up, m_down);
      end
      push_model(tag);
      @(posedge clock_12);
      #1 recenter = 1'b0;
      check_out();
      if (hold_cycles > 1) begin
         repeat (hold_cycles - 1) @(posedge clock_12);
         #1 tick_4ms = 1'b0;
         @(posedge clock_12);
         #1 push_model({tag, "_held"});
         check_out();
      end else begin
         tick_4ms = 1'b0;
      end
   endtask

   task automatic ticks(input string tag, input int n);
      for (int i = 0; i < n; i++) tick_step(tag, 1, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clock_12);
      #3 reset = 1'b1;
      #4 reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout, required finish");
      $fatal(1);
   end

   initial begin
      model_reset();

      // reset release with tick held high, no input
      repeat (3) @(posedge clock_12);
      #1 reset = 1'b0;
      repeat (3) @(posedge clock_12);
      #1 push_const("rst_release", 32, 32);
      check_out();
      tick_4ms = 1'b0;
      ticks("idle_tick", 3);
      push_const("idle_done", 32, 32);
      check_out();

      // release with tick high while a direction is held: still no step
      tick_4ms = 1'b1;
      m_right  = 1'b1;
      #3 reset = 1'b1;
      #4 reset = 1'b0;
      model_reset();
      repeat (3) @(posedge clock_12);
      #1 push_const("rst_release_dir", 32, 32);
      check_out();
      tick_4ms = 1'b0;

      // acceleration and right-edge saturation
      ticks("accel", 24);
      push_const("accel_24", 42, 32);
      check_out();
      ticks("accel_fast", 21);
      push_const("accel_45", 63, 32);
      check_out();
      ticks("sat_right", 3);
      push_const("sat_right_hold", 63, 32);
      check_out();
      m_right = 1'b0;

      // fractional floor, including one tick held high for several cycles
      do_reset();
      m_left = 1'b1;
      tick_step("floor1", 1, 1'b0);
      push_const("floor_1", 31, 32);
      check_out();
      tick_step("floor_hold", 6, 1'b0);
      ticks("floor", 2);
      push_const("floor_4", 31, 32);
      check_out();
      ticks("floor", 1);
      push_const("floor_5", 30, 32);
      check_out();
      m_left = 1'b0;

      // reversal and conflicting inputs
      do_reset();
      m_right = 1'b1;
      ticks("rev_right", 30);
      push_const("rev_30", 48, 32);
      check_out();
      m_right = 1'b0;
      m_left  = 1'b1;
      ticks("rev_left", 1);
      push_const("rev_first_left", 47, 32);
      check_out();
      m_right = 1'b1;
      ticks("conflict", 2);
      push_const("conflict_still", 47, 32);
      check_out();
      m_left = 1'b0;
      ticks("after_conflict", 1);
      push_const("after_conflict_slow", 48, 32);
      check_out();
      m_right = 1'b0;

      // vertical saturation at 0, then recenter coinciding with a tick
      do_reset();
      m_up = 1'b1;
      ticks("up", 46);
      push_const("up_at_0", 32, 0);
      check_out();
      ticks("up_sat", 10);
      push_const("up_sat_0", 32, 0);
      check_out();
      tick_step("recenter_tick", 1, 1'b1);
      push_const("recenter_32", 32, 32);
      check_out();
      m_up   = 1'b0;
      m_down = 1'b1;
      m_left = 1'b1;
      ticks("diag", 4);
      push_const("diag_4", 31, 33);
      check_out();
      m_down = 1'b0;
      m_left = 1'b0;

      // asynchronous reset during a fast hold
      do_reset();
      m_right = 1'b1;
      ticks("fast_right", 30);
      @(posedge clock_12);
      #3 reset = 1'b1;
      #1 model_reset();
      push_const("async_rst", 32, 32);
      check_out();
      #2 reset = 1'b0;
      ticks("post_rst", 1);
      push_const("post_rst_1", 32, 32);
      check_out();
      ticks("post_rst", 3);
      push_const("post_rst_4", 33, 32);
      check_out();
      m_right = 1'b0;

      check_all();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
